// File: rtl/msi001_spi_arbiter_pkg.sv
// Shared definitions for the MSI001 SPI configuration path: FSM state encoding,
// tuner word width and requester indices.
package sdr_spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_t;

  localparam int   MSI001_WORD_W = 24;
  localparam logic REQ_CPU       = 1'b0;
  localparam logic REQ_SCAN      = 1'b1;

endpackage

// File: rtl/msi001_spi_arbiter_if.sv
// Requester handshake and status bundle between the two SPI requesters
// (CPU register path, scan sequencer) and the arbiter.
interface msi001_spi_arbiter_if
  import sdr_spi_pkg::*;
#(
  parameter int DATA_W = MSI001_WORD_W
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              busy;
  logic              done;
  logic              done_id;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, busy, done, done_id
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, busy, done, done_id
  );
endinterface

// File: rtl/msi001_spi_arbiter_spi_tx_shifter.sv
// SPI serialiser: half-period divider, bit counter, shift register and the
// registered SPI_CLK / SDO pins. Segment-end strobes pace the top-level FSM.
module spi_tx_shifter
  import sdr_spi_pkg::*;
#(
  parameter int DATA_W  = MSI001_WORD_W,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  spi_state_t        state,
  output logic              setup_end,
  output logic              shift_end,
  output logic              frame_end,
  output logic              spi_clk,
  output logic              spi_sdo
);
  localparam int BIT_W = $clog2(DATA_W);

  logic [7:0]        div_cnt_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [DATA_W-1:0] shreg_r;
  logic              spi_clk_r;
  logic              spi_sdo_r;
  logic              div_end_s;
  logic              fall_s;
  logic              active_s;

  assign active_s  = (state == SETUP) || (state == SHIFT) || (state == HOLD);
  assign div_end_s = (div_cnt_r == 8'(CLK_DIV - 1));
  // spi_clk_r doubles as the high-phase flag, so a divider wrap while high is a falling edge
  assign fall_s    = (state == SHIFT) && div_end_s && spi_clk_r;
  assign setup_end = (state == SETUP) && div_end_s;
  assign shift_end = fall_s && (bit_cnt_r == {BIT_W{1'b0}});
  assign frame_end = (state == HOLD) && div_end_s;
  assign spi_clk   = spi_clk_r;
  assign spi_sdo   = spi_sdo_r;

  // Divider, serial clock and data shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= 8'd0;
      bit_cnt_r <= {BIT_W{1'b0}};
      shreg_r   <= {DATA_W{1'b0}};
      spi_clk_r <= 1'b0;
      spi_sdo_r <= 1'b0;
    end else if (start) begin
      div_cnt_r <= 8'd0;
      bit_cnt_r <= BIT_W'(DATA_W - 1);
      shreg_r   <= data;
      spi_clk_r <= 1'b0;
      spi_sdo_r <= data[DATA_W-1];
    end else begin
      if (active_s && !div_end_s) begin
        div_cnt_r <= div_cnt_r + 8'd1;
      end else begin
        div_cnt_r <= 8'd0;
      end

      if ((state == SHIFT) && div_end_s) begin
        spi_clk_r <= ~spi_clk_r;
      end else if (state == SHIFT) begin
        spi_clk_r <= spi_clk_r;
      end else begin
        spi_clk_r <= 1'b0;
      end

      if (fall_s) begin
        shreg_r   <= {shreg_r[DATA_W-2:0], 1'b0};
        spi_sdo_r <= shreg_r[DATA_W-2];
        if (bit_cnt_r != {BIT_W{1'b0}}) begin
          bit_cnt_r <= bit_cnt_r - BIT_W'(1);
        end else begin
          bit_cnt_r <= bit_cnt_r;
        end
      end else if (frame_end || !active_s) begin
        spi_sdo_r <= 1'b0;
      end else begin
        spi_sdo_r <= spi_sdo_r;
      end
    end
  end
endmodule

// File: rtl/msi001_spi_arbiter.sv
// Two-requester SPI arbiter for the MSI001 tuner: arbitration, frame FSM and CS/GAP timing.
// Define SPI_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module msi001_spi_arbiter
  import sdr_spi_pkg::*;
#(
  parameter int DATA_W  = MSI001_WORD_W,
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 8
) (
  input  logic                clk,
  input  logic                RSTn,
  msi001_spi_arbiter_if.slave bus,
  output logic                SPI_CLK,
  output logic                SPI_CS_0,
  output logic                SPI_SDO_0
);
  spi_state_t        state_r;
  spi_state_t        next_s;
  logic [7:0]        gap_cnt_r;
  logic              cs_r;
  logic              busy_r;
  logic              done_r;
  logic              done_id_r;
  logic              cur_id_r;
  logic              gnt0_s;
  logic              gnt1_s;
  logic              accept_s;
  logic [DATA_W-1:0] data_s;
  logic              setup_end_s;
  logic              shift_end_s;
  logic              frame_end_s;
`ifndef SPI_ARB_FIXED_PRIO_EN
  logic              last_grant_r;
`endif

  // Grant selection, only while idle
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (state_r == IDLE) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
      gnt0_s = bus.req0_valid;
      gnt1_s = bus.req1_valid & ~bus.req0_valid;
`else
      gnt1_s = bus.req1_valid & (~bus.req0_valid | (last_grant_r == REQ_CPU));
      gnt0_s = bus.req0_valid & ~gnt1_s;
`endif
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign accept_s       = gnt0_s | gnt1_s;
  assign data_s         = gnt1_s ? bus.req1_data : bus.req0_data;
  assign bus.req0_ready = gnt0_s;
  assign bus.req1_ready = gnt1_s;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.done_id    = done_id_r;
  assign SPI_CS_0       = cs_r;

  // Frame sequencing
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE:    next_s = accept_s ? SETUP : IDLE;
      SETUP:   next_s = setup_end_s ? SHIFT : SETUP;
      SHIFT:   next_s = shift_end_s ? HOLD : SHIFT;
      HOLD:    next_s = frame_end_s ? GAP : HOLD;
      GAP:     next_s = (gap_cnt_r == 8'(GAP_CYC - 1)) ? IDLE : GAP;
      default: next_s = IDLE;
    endcase
  end

  // State register and registered status outputs, derived from the next state
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_r   <= IDLE;
      gap_cnt_r <= 8'd0;
      cs_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      done_id_r <= REQ_CPU;
      cur_id_r  <= REQ_CPU;
    end else begin
      state_r   <= next_s;
      gap_cnt_r <= (state_r == GAP) ? gap_cnt_r + 8'd1 : 8'd0;
      cs_r      <= !((next_s == SETUP) || (next_s == SHIFT) || (next_s == HOLD));
      busy_r    <= (next_s != IDLE);
      done_r    <= frame_end_s;
      done_id_r <= frame_end_s ? cur_id_r : done_id_r;
      cur_id_r  <= accept_s ? (gnt1_s ? REQ_SCAN : REQ_CPU) : cur_id_r;
    end
  end

`ifndef SPI_ARB_FIXED_PRIO_EN
  // Round-robin history; resets to the scan requester so the CPU wins the first tie
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      last_grant_r <= REQ_SCAN;
    end else if (accept_s) begin
      last_grant_r <= gnt1_s ? REQ_SCAN : REQ_CPU;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

  spi_tx_shifter #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (RSTn),
    .start     (accept_s),
    .data      (data_s),
    .state     (state_r),
    .setup_end (setup_end_s),
    .shift_end (shift_end_s),
    .frame_end (frame_end_s),
    .spi_clk   (SPI_CLK),
    .spi_sdo   (SPI_SDO_0)
  );
endmodule

// File: tb/tb_msi001_spi_arbiter.sv
// Directed bench for msi001_spi_arbiter (default round-robin build, default parameters).
module tb_msi001_spi_arbiter;
  logic clk;
  logic RSTn;
  logic SPI_CLK;
  logic SPI_CS_0;
  logic SPI_SDO_0;

  int n_cmp  = 0;
  int n_fail = 0;

  // frame observation results
  int          cs_low;
  int          rises;
  logic [23:0] word;
  int          dones;
  logic        did;
  int          sdo_bad = 0;

  int who;
  int wcyc;
  int cs_hi;
  int dn;

  msi001_spi_arbiter_if #(.DATA_W(24)) bus ();

  msi001_spi_arbiter #(
    .DATA_W  (24),
    .CLK_DIV (4),
    .GAP_CYC (8)
  ) dut (
    .clk       (clk),
    .RSTn      (RSTn),
    .bus       (bus),
    .SPI_CLK   (SPI_CLK),
    .SPI_CS_0  (SPI_CS_0),
    .SPI_SDO_0 (SPI_SDO_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for either ready; counts non-granting cycles and CS-high samples.
  task automatic wait_grant(output int w_who, output int w_cyc, output int w_hi);
    w_who = -1;
    w_cyc = 0;
    w_hi  = 0;
    for (int i = 0; i < 600; i++) begin
      #1;
      if (SPI_CS_0) w_hi++;
      if (SPI_CS_0 && SPI_SDO_0) sdo_bad++;
      if (bus.req0_ready) begin
        w_who = 0;
        break;
      end
      if (bus.req1_ready) begin
        w_who = 1;
        break;
      end
      w_cyc++;
      @(negedge clk);
    end
  endtask

  // Samples the current cycle onward until done (bounded); records SPI activity.
  task automatic watch_frame();
    logic prev_clk;
    cs_low   = 0;
    rises    = 0;
    word     = 24'h000000;
    dones    = 0;
    did      = 1'b0;
    prev_clk = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!SPI_CS_0) cs_low++;
      if (SPI_CS_0 && SPI_SDO_0) sdo_bad++;
      if (SPI_CLK && !prev_clk) begin
        rises++;
        word = {word[22:0], SPI_SDO_0};
      end
      prev_clk = SPI_CLK;
      if (bus.done) begin
        dones++;
        did = bus.done_id;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send0(input logic [23:0] d);
    bus.req0_data  = d;
    bus.req0_valid = 1'b1;
    wait_grant(who, wcyc, cs_hi);
    check("grant_req0", who, 0);
    @(negedge clk);
    #1;
    check("ready0_one_pulse", {31'd0, bus.req0_ready}, 0);
    bus.req0_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [23:0] exp_word, input logic exp_id);
    check({tag, "_cs_low"}, cs_low, 200);
    check({tag, "_rises"}, rises, 24);
    check({tag, "_word"}, {8'd0, word}, {8'd0, exp_word});
    check({tag, "_done"}, dones, 1);
    check({tag, "_done_id"}, {31'd0, did}, {31'd0, exp_id});
  endtask

  initial begin
    logic [23:0] exp_w [4];
    int          exp_g [4];
    exp_w[0] = 24'h000001; exp_g[0] = 0;
    exp_w[1] = 24'h800000; exp_g[1] = 1;
    exp_w[2] = 24'h000001; exp_g[2] = 0;
    exp_w[3] = 24'h800000; exp_g[3] = 1;

    RSTn           = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_data  = 24'h000000;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 24'h000000;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_cs", {31'd0, SPI_CS_0}, 1);
    check("rst_clk", {31'd0, SPI_CLK}, 0);
    check("rst_sdo", {31'd0, SPI_SDO_0}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    RSTn = 1'b1;
    @(negedge clk);

    // single frame from requester 0
    send0(24'hA5F00F);
    watch_frame();
    check_frame("single", 24'hA5F00F, 1'b0);

    // busy blocking: req1 raised during req0's SHIFT
    repeat (20) @(negedge clk);
    send0(24'h0F0F0F);
    repeat (19) @(negedge clk);
    #1;
    check("busy_in_shift", {31'd0, bus.busy}, 1);
    check("cs_low_in_shift", {31'd0, SPI_CS_0}, 0);
    bus.req1_data  = 24'h123456;
    bus.req1_valid = 1'b1;
    wait_grant(who, wcyc, cs_hi);
    check("blocked_grant", who, 1);
    check("blocked_wait", wcyc, 189);
    @(negedge clk);
    #1;
    bus.req1_valid = 1'b0;
    watch_frame();
    check_frame("blocked", 24'h123456, 1'b1);

    // simultaneous requests: round-robin 0,1,0,1 with GAP + IDLE between frames
    bus.req0_data  = 24'h000001;
    bus.req1_data  = 24'h800000;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(who, wcyc, cs_hi);
      check("rr_grant", who, exp_g[k]);
      check("rr_gap_cycles", wcyc, 8);
      check("rr_cs_high", cs_hi, 9);
      @(negedge clk);
      #1;
      watch_frame();
      check_frame("rr", exp_w[k], exp_g[k][0]);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("rr_idle_busy", {31'd0, bus.busy}, 0);

    // reset mid-frame during bit 10's high phase
    send0(24'hFFFFFF);
    repeat (113) @(negedge clk);
    #1;
    check("mid_cs_low", {31'd0, SPI_CS_0}, 0);
    check("mid_clk_high", {31'd0, SPI_CLK}, 1);
    #1;
    RSTn = 1'b0;
    #1;
    check("async_cs", {31'd0, SPI_CS_0}, 1);
    check("async_clk", {31'd0, SPI_CLK}, 0);
    check("async_sdo", {31'd0, SPI_SDO_0}, 0);
    check("async_busy", {31'd0, bus.busy}, 0);
    repeat (2) @(negedge clk);
    RSTn = 1'b1;
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("abort_no_done", dn, 0);
    send0(24'h3C5A96);
    watch_frame();
    check_frame("after_rst", 24'h3C5A96, 1'b0);

    check("sdo_zero_cs_high", sdo_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/msi001_spi_arbiter.md
# msi001_spi_arbiter

Arbitrated SPI configuration controller for the MSI001 tuner. It shares the single write-only 3-wire SPI port (SPI_CLK / SPI_CS_0 / SPI_SDO_0) between two requesters: requester 0 is the CPU APB register path, and requester 1 is the hardware scan/retune sequencer. It accepts 24-bit register words through valid/ready handshakes and arbitrates between them round-robin. Each accepted word is serialised MSB-first as a complete framed transfer. The block sits between the peripheral bus bridge and the SDR_Pad SPI pins.

## Interface
Parameters:
- DATA_W, 24, SPI word width in bits (MSI001 register word).
- CLK_DIV, 4, SPI_CLK half-period in clk cycles; legal range 1..255.
- GAP_CYC, 8, minimum clk cycles SPI_CS_0 stays high between frames; legal range 1..255.

Ports:
- clk  in  1  system clock; single clock domain.
- RSTn  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a word pending.
- req0_data  in  DATA_W  requester 0 word.
- req0_ready  out  1  one-cycle accept pulse for requester 0.
- req1_valid  in  1  requester 1 has a word pending.
- req1_data  in  DATA_W  requester 1 word.
- req1_ready  out  1  one-cycle accept pulse for requester 1.
- busy  out  1  high from accept through the end of GAP.
- done  out  1  one-cycle pulse when SPI_CS_0 deasserts.
- done_id  out  1  requester index of the frame that finished; valid with done.
- SPI_CLK  out  1  serial clock; idles low.
- SPI_CS_0  out  1  active-low chip select.
- SPI_SDO_0  out  1  serial data, MSB first.

## Operation
- FSM states are IDLE, SETUP, SHIFT, HOLD and GAP.
- IDLE: if any valid is high, grant one requester.
  - When both are valid, grant the requester other than last_grant; last_grant resets to 1, so requester 0 wins the first contest.
  - In the grant cycle: pulse that requester's ready, capture its data into the shift register, update last_grant, go to SETUP.
- SETUP: SPI_CS_0=0, SPI_SDO_0=MSB, SPI_CLK=0 for CLK_DIV cycles.
- SHIFT: DATA_W bits, each taking 2*CLK_DIV cycles.
  - SPI_CLK is low for the first CLK_DIV cycles of the bit and high for the second CLK_DIV.
  - SPI_SDO_0 changes only on the SPI_CLK falling edge; the tuner samples on the rising edge.
  - The bit counter counts DATA_W-1 down to 0; leave SHIFT after bit 0's high phase.
- HOLD: SPI_CLK=0, SPI_CS_0=0 for CLK_DIV cycles, then SPI_CS_0 goes to 1.
- GAP: SPI_CS_0=1 for GAP_CYC cycles; done and done_id pulse on the first GAP cycle; return to IDLE.
- Requests seen while not in IDLE are not accepted. Their ready stays low; requesters must hold valid and data stable until ready.
- valid dropping before ready is legal; the block samples valid only in IDLE.
- SPI_SDO_0 is 0 whenever SPI_CS_0=1.

## Timing
- Reset values (asynchronous): SPI_CS_0=1, SPI_CLK=0, SPI_SDO_0=0, req*_ready=0, busy=0, done=0, done_id=0, last_grant=1, state IDLE.
- Accept latency: ready is asserted in the same cycle valid is seen in IDLE; the request-to-ready path is combinational from the registered state.
- SPI_CS_0 falls the cycle after accept.
- Chip-select low time = CLK_DIV*(2*DATA_W+2) cycles; with defaults, 200 cycles.
- Accept-to-accept minimum = 1 + 200 + GAP_CYC; with defaults, 209 cycles.
- The FSM returns to IDLE after the last GAP cycle. A pending request is accepted in that IDLE cycle, so back-to-back frames have exactly GAP_CYC cycles of CS high plus the IDLE cycle.
- Reset mid-frame: all outputs return to reset values immediately; the frame is aborted with no done pulse. The word is lost, and the requester must re-issue.
- All outputs are registered except req*_ready.

## Configuration
- SPI_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins over requester 1; last_grant is not implemented.
- SPI_ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Structure
- Shared package sdr_spi_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, HOLD, GAP);
  - MSI001_WORD_W = 24;
  - requester index constants REQ_CPU = 0 and REQ_SCAN = 1.
- Sub-module spi_tx_shifter holds the divider counter, bit counter, shift register, SPI_CLK and SPI_SDO_0 generation.
  - Its interface is a start/data input with a frame_end output.
- The top level holds the arbiter, the FSM and chip-select/GAP timing.

## Test plan
- Reset: hold RSTn=0 -> SPI_CS_0=1, SPI_CLK=0, SPI_SDO_0=0, busy=0, both ready=0.
- Single frame, defaults: req0 with 24'hA5F00F -> req0_ready pulses once; CS low 200 cycles; 24 SPI_CLK rising edges; bits sampled at the rising edges read 1010_0101_1111_0000_0000_1111; done=1 with done_id=0.
- Simultaneous requests: req0=24'h000001 and req1=24'h800000 held together -> grant order 0,1,0,1 across four frames; CS-high gap is 8 cycles plus the IDLE cycle each time.
- Busy blocking: assert req1 during req0's SHIFT -> req1_ready stays low until the cycle after GAP ends.
- Reset mid-frame: drop RSTn at bit 10 -> CS goes high asynchronously, no done pulse; the next req0 transfers a full 24 bits cleanly.
- SPI_ARB_FIXED_PRIO_EN defined: req0 and req1 continuously valid -> req0 is granted every frame and req1 never until req0 drops.
